// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-read FIFO into a valid/ready stream, tagging every BURST_LEN-th beat
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    logic [1:0]       occ;
    logic [1:0]       level;
    logic             inflight;
    logic             head;
    logic             tail;
    logic             pop;
    logic [BW-1:0]    beat;
    logic [WIDTH-1:0] mem [2];
    assign pop        = m_valid & m_ready;
    assign level      = occ + {1'b0, inflight} - {1'b0, pop};
    assign fifo_rd_en = rst_n & en & ~fifo_empty & (level < 2'd2);
    assign m_valid    = occ != 2'd0;
    assign m_data     = mem[head];
    assign m_last     = m_valid & (beat == LAST_BEAT);
    assign busy       = m_valid | inflight;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
            head     <= 1'b0;
            tail     <= 1'b0;
            beat     <= '0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            occ      <= level;
            inflight <= fifo_rd_en;
            if (inflight) begin
                mem[tail] <= fifo_rd_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
                beat <= beat == LAST_BEAT ? '0 : beat + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO model + scoreboard bench for fifo_rd_stream
module tb_fifo_rd_stream;
    localparam int W  = 8;
    localparam int BL = 4;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_rd_data = '0;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         busy;

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic         en;
        logic         rdy;
        logic         rd_en;
        logic         valid;
        logic         busy;
        logic [W-1:0] data;
    } vec_t;

    logic [W-1:0] fifo_q [$];
    beat_t        exp_q [$];
    int           total = 0;
    int           bad = 0;
    int           exp_beat = 0;
    int           reads = 0;
    int           deliv = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_data = '0;
    logic         held_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back('{data: d, last: logic'(exp_beat == BL - 1)});
        exp_beat = (exp_beat + 1) % BL;
        fifo_empty <= 1'b0;
    endtask

    task automatic sample();
        beat_t e;
        @(negedge clk);
        if (rst_n) begin
            chk("rd_en_when_empty", fifo_rd_en & fifo_empty, 0);
            chk("outstanding_le_2", (reads - deliv) > 2, 0);
            if (stall_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, held_data);
                chk("hold_last", m_last, held_last);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected no beat at %0t", m_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.data);
                    chk("beat_last", m_last, e.last);
                end
                deliv++;
            end
            stall_prev = m_valid & ~m_ready;
            held_data  = m_data;
            held_last  = m_last;
        end else begin
            stall_prev = 1'b0;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_q.pop_front();
            fifo_empty   <= fifo_q.size() == 0;
            reads++;
        end
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            adv();
        end
    endtask

    vec_t tv [11];
    int   r0;
    int   d0;

    initial begin
        // T1: reset with a non-empty FIFO and en high
        rst_n   = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        fifo_q.push_back(8'hAA);
        fifo_empty <= 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_data", m_data, 0);
            chk("rst_last", m_last, 0);
            adv();
        end
        rst_n = 1'b1;
        en    = 1'b0;
        fifo_q.delete();
        fifo_empty <= 1'b1;

        // T2: streaming, table-driven per-cycle expectations
        for (int i = 1; i <= 8; i++) push(W'(i));
        tv[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
        tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01};
        tv[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02};
        tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03};
        tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04};
        tv[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05};
        tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h06};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08};
        tv[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int r = 0; r < 11; r++) begin
            en      = tv[r].en;
            m_ready = tv[r].rdy;
            sample();
            chk($sformatf("t2_rd_en[%0d]", r), fifo_rd_en, tv[r].rd_en);
            chk($sformatf("t2_valid[%0d]", r), m_valid, tv[r].valid);
            chk($sformatf("t2_busy[%0d]", r), busy, tv[r].busy);
            if (tv[r].valid) chk($sformatf("t2_data[%0d]", r), m_data, tv[r].data);
            adv();
        end
        chk("t2_drained", exp_q.size(), 0);

        // T3: backpressure in cycles 3..6
        for (int i = 0; i < 8; i++) push(W'(8'h11 + i));
        for (int c = 0; c < 20; c++) begin
            m_ready = !(c >= 3 && c <= 6);
            sample();
            if (c == 5) begin
                chk("t3_stall_data", m_data, 8'h12);
                chk("t3_stall_rd_en", fifo_rd_en, 0);
                chk("t3_fifo_left", fifo_q.size(), 5);
            end
            adv();
        end
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_busy_idle", busy, 0);

        // T4: single word, then refill later
        m_ready = 1'b1;
        r0 = reads;
        d0 = deliv;
        push(8'h21);
        step(6);
        chk("t4_one_read", reads - r0, 1);
        chk("t4_one_beat", deliv - d0, 1);
        step(3);
        push(8'h55);
        push(8'h56);
        push(8'h57);
        step(8);
        chk("t4_drained", exp_q.size(), 0);

        // T5: en gating mid-stream
        for (int i = 0; i < 6; i++) push(W'(8'h31 + i));
        step(3);
        en = 1'b0;
        sample();
        chk("t5_rd_en_gated", fifo_rd_en, 0);
        adv();
        step(4);
        chk("t5_busy_low", busy, 0);
        chk("t5_valid_low", m_valid, 0);
        chk("t5_fifo_left", fifo_q.size(), 3);
        chk("t5_exp_left", exp_q.size(), 3);
        en = 1'b1;
        step(8);
        chk("t5_drained", exp_q.size(), 0);

        // T6: reset mid-burst with words buffered
        for (int i = 0; i < 8; i++) push(W'(8'h41 + i));
        step(4);
        m_ready = 1'b0;
        step(2);
        chk("t6_buffered", busy, 1);
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty <= 1'b1;
        exp_beat = 0;
        reads = 0;
        deliv = 0;
        sample();
        adv();
        sample();
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_data", m_data, 0);
        chk("t6_rst_last", m_last, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rd_en", fifo_rd_en, 0);
        adv();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(W'(8'h61 + i));
        step(8);
        chk("t6_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
